// File: rtl/blowfish_decrypt_core.sv
// Iterative Blowfish decryption engine.
// One Feistel round takes two clocks: LOOKUP presents S-box indices, CALC folds in the S-box data.
// The P-array is held locally and walked from ROUNDS+1 down to 2. S-boxes live outside in synchronous memory.
module blowfish_decrypt_core #(
  parameter int unsigned ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  input  logic        p_we,
  input  logic [4:0]  p_addr,
  input  logic [31:0] p_wdata,
  output logic        sbox_rd,
  output logic [7:0]  sbox_addr0,
  output logic [7:0]  sbox_addr1,
  output logic [7:0]  sbox_addr2,
  output logic [7:0]  sbox_addr3,
  input  logic [31:0] sbox_data0,
  input  logic [31:0] sbox_data1,
  input  logic [31:0] sbox_data2,
  input  logic [31:0] sbox_data3,
  output logic        busy
);

  localparam int unsigned DEPTH = ROUNDS + 2;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(ROUNDS + 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_CALC   = 3'd2,
    S_FINAL  = 3'd3,
    S_HOLD   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      l_q, l_d;
  logic [31:0]      r_q, r_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      p_q [DEPTH];
  logic [31:0]      p_d [DEPTH];
  logic             out_valid_q, out_valid_d;
  logic [63:0]      out_data_q, out_data_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             sbox_rd_q, sbox_rd_d;

  logic [31:0]      t_c;
  logic [31:0]      f_c;
  logic             p_wr_en_c;

  // Current half-block whitened with the round key; this is what the S-boxes index
  always_comb begin
    t_c = l_q ^ p_q[idx_q];
  end

  // Blowfish F function over the S-box words returned for the previous LOOKUP
  always_comb begin
    f_c = ((sbox_data0 + sbox_data1) ^ sbox_data2) + sbox_data3;
  end

  // S-box indices are driven only while a read is requested, zero otherwise
  always_comb begin
    sbox_addr0 = 8'h00;
    sbox_addr1 = 8'h00;
    sbox_addr2 = 8'h00;
    sbox_addr3 = 8'h00;
    if (sbox_rd_q) begin
      sbox_addr0 = t_c[31:24];
      sbox_addr1 = t_c[23:16];
      sbox_addr2 = t_c[15:8];
      sbox_addr3 = t_c[7:0];
    end
  end

  // P-array writes land only while idle and not on an accepting edge; out-of-range indices fall through
  always_comb begin
    p_wr_en_c = p_we && (state_q == S_IDLE) && !in_valid;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      p_d[i] = p_q[i];
      if (p_wr_en_c && (p_addr == 5'(i))) begin
        p_d[i] = p_wdata;
      end
    end
  end

  // Next-state, datapath and registered-status decode
  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    r_d         = r_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          l_d     = in_data[63:32];
          r_d     = in_data[31:0];
          idx_d   = IDX_FIRST;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        l_d     = t_c;
        state_d = S_CALC;
      end
      S_CALC: begin
        l_d     = r_q ^ f_c;
        r_d     = l_q;
        idx_d   = idx_q - IDX_ONE;
        state_d = (idx_q == IDX_LAST) ? S_FINAL : S_LOOKUP;
      end
      S_FINAL: begin
        // Swapping back here undoes the swap of the final round
        out_data_d  = {r_q ^ p_q[0], l_q ^ p_q[1]};
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
    sbox_rd_d  = (state_d == S_LOOKUP);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, P-array and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      l_q         <= 32'h0;
      r_q         <= 32'h0;
      idx_q       <= '0;
      p_q         <= '{default: 32'h0};
      out_valid_q <= 1'b0;
      out_data_q  <= 64'h0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      sbox_rd_q   <= 1'b0;
    end else begin
      l_q         <= l_d;
      r_q         <= r_d;
      idx_q       <= idx_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      sbox_rd_q   <= sbox_rd_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign sbox_rd   = sbox_rd_q;

endmodule

// File: tb/tb_blowfish_decrypt_core.sv
// Self-checking bench for blowfish_decrypt_core.
// Standard Blowfish constants are derived here from pi (Machin formula, multi-limb fixed point),
// then the all-zero-key schedule is run through a reference encrypt model.
`timescale 1ns/1ps
module tb_blowfish_decrypt_core;

  localparam int unsigned ROUNDS = 16;
  localparam int NP = ROUNDS + 2;
  localparam int NW = 18 + 1024;
  localparam int NL = NW + 4;
  localparam int MAX_WAIT = 200;
  localparam int BA = 0;
  localparam int BB = 1;
  localparam int BP = 2;
  localparam int BT = 3;
  localparam logic [63:0] LAT = 64'(2 * ROUNDS + 1);

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        p_we;
  logic [4:0]  p_addr;
  logic [31:0] p_wdata;
  logic        sbox_rd;
  logic [7:0]  sbox_addr0, sbox_addr1, sbox_addr2, sbox_addr3;
  logic [31:0] sbox_data0, sbox_data1, sbox_data2, sbox_data3;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned bn [0:3][0:NL-1];
  logic [31:0] p_m [0:17];
  logic [31:0] s_m [0:3][0:255];
  bit          sbox_zero;

  typedef struct packed {
    logic        std_key;
    logic [63:0] din;
    logic [63:0] exp;
  } vec_t;
  localparam int NV = 7;
  vec_t vecs [0:NV-1];

  blowfish_decrypt_core #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .sbox_rd(sbox_rd),
    .sbox_addr0(sbox_addr0), .sbox_addr1(sbox_addr1),
    .sbox_addr2(sbox_addr2), .sbox_addr3(sbox_addr3),
    .sbox_data0(sbox_data0), .sbox_data1(sbox_data1),
    .sbox_data2(sbox_data2), .sbox_data3(sbox_data3),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous S-box memory; junk when not read so misuse of stale data shows up
  always @(posedge clk) begin
    if (sbox_rd) begin
      sbox_data0 <= sbox_zero ? 32'h0 : s_m[0][sbox_addr0];
      sbox_data1 <= sbox_zero ? 32'h0 : s_m[1][sbox_addr1];
      sbox_data2 <= sbox_zero ? 32'h0 : s_m[2][sbox_addr2];
      sbox_data3 <= sbox_zero ? 32'h0 : s_m[3][sbox_addr3];
    end else begin
      sbox_data0 <= 32'hA5A5_0000;
      sbox_data1 <= 32'h5A5A_1111;
      sbox_data2 <= 32'h3C3C_2222;
      sbox_data3 <= 32'hC3C3_3333;
    end
  end

  // ---------------- multi-limb fixed point (limb 0 = integer part) ----------------
  task automatic bn_clear(input int a);
    for (int i = 0; i < NL; i++) bn[a][i] = 0;
  endtask

  task automatic bn_copy(input int d, input int s);
    for (int i = 0; i < NL; i++) bn[d][i] = bn[s][i];
  endtask

  task automatic bn_div(input int a, input int unsigned dv);
    longint unsigned rem, cur;
    rem = 0;
    for (int i = 0; i < NL; i++) begin
      cur = (rem << 32) | 64'(bn[a][i]);
      bn[a][i] = 32'(cur / 64'(dv));
      rem = cur % 64'(dv);
    end
  endtask

  task automatic bn_mul(input int a, input int unsigned m);
    longint unsigned carry, cur;
    carry = 0;
    for (int i = NL - 1; i >= 0; i--) begin
      cur = 64'(bn[a][i]) * 64'(m) + carry;
      bn[a][i] = cur[31:0];
      carry = cur >> 32;
    end
  endtask

  task automatic bn_addsub(input int d, input int s, input bit sub);
    longint unsigned cur;
    bit c;
    c = 1'b0;
    for (int i = NL - 1; i >= 0; i--) begin
      if (!sub) begin
        cur = 64'(bn[d][i]) + 64'(bn[s][i]) + 64'(c);
        c = cur[32];
      end else begin
        cur = 64'(bn[d][i]) - 64'(bn[s][i]) - 64'(c);
        c = cur[63];
      end
      bn[d][i] = cur[31:0];
    end
  endtask

  function automatic bit bn_zero(input int a);
    for (int i = 0; i < NL; i++) if (bn[a][i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic atan_inv(input int acc, input int unsigned n);
    int unsigned k;
    bn_clear(acc);
    bn_clear(BP);
    bn[BP][0] = 1;
    bn_div(BP, n);
    k = 0;
    while (!bn_zero(BP)) begin
      bn_copy(BT, BP);
      bn_div(BT, 2 * k + 1);
      bn_addsub(acc, BT, k[0]);
      bn_div(BP, n * n);
      k++;
    end
  endtask

  // ---------------- reference Blowfish (encrypt direction) ----------------
  function automatic logic [31:0] f_fn(input logic [31:0] x);
    return ((s_m[0][x[31:24]] + s_m[1][x[23:16]]) ^ s_m[2][x[15:8]]) + s_m[3][x[7:0]];
  endfunction

  function automatic logic [63:0] enc(input logic [63:0] blk);
    logic [31:0] xl, xr, tmp;
    xl = blk[63:32];
    xr = blk[31:0];
    for (int i = 0; i < 16; i++) begin
      xl = xl ^ p_m[i];
      xr = xr ^ f_fn(xl);
      tmp = xl; xl = xr; xr = tmp;
    end
    tmp = xl; xl = xr; xr = tmp;
    xr = xr ^ p_m[16];
    xl = xl ^ p_m[17];
    return {xl, xr};
  endfunction

  task automatic build_std_key;
    logic [63:0] blk;
    atan_inv(BA, 5);
    bn_mul(BA, 4);
    atan_inv(BB, 239);
    bn_addsub(BA, BB, 1'b1);
    bn_mul(BA, 4);
    for (int i = 0; i < 18; i++) p_m[i] = bn[BA][1 + i];
    for (int b = 0; b < 4; b++)
      for (int e = 0; e < 256; e++) s_m[b][e] = bn[BA][1 + 18 + 256 * b + e];
    // Zero key: the key XOR leaves P untouched, then the usual 521 encryptions
    blk = 64'h0;
    for (int i = 0; i < 18; i += 2) begin
      blk = enc(blk);
      p_m[i] = blk[63:32];
      p_m[i + 1] = blk[31:0];
    end
    for (int b = 0; b < 4; b++)
      for (int e = 0; e < 256; e += 2) begin
        blk = enc(blk);
        s_m[b][e] = blk[63:32];
        s_m[b][e + 1] = blk[31:0];
      end
  endtask

  // ---------------- bench utilities ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic load_p(input bit zero);
    for (int i = 0; i < NP; i++) begin
      p_we = 1'b1;
      p_addr = 5'(i);
      p_wdata = zero ? 32'h0 : p_m[i];
      step();
    end
    p_we = 1'b0;
    p_addr = 5'h0;
    p_wdata = 32'h0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < MAX_WAIT) begin
      step();
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic accept(input logic [63:0] din);
    int w;
    w = 0;
    while (!in_ready && w < MAX_WAIT) begin
      step();
      w++;
    end
    in_valid = 1'b1;
    in_data = din;
    step();
    in_valid = 1'b0;
    in_data = 64'h0;
  endtask

  task automatic run_block(input string name, input logic [63:0] din, input logic [63:0] exp);
    int lat;
    accept(din);
    wait_out(lat);
    chk({name, " latency"}, 64'(lat), LAT);
    chk({name, " data"}, out_data, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({name, " idle after handshake"}, {62'h0, in_ready, out_valid}, 64'h2);
  endtask

  // Hard stop in case the run wanders off
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cur_mode;
    bit seen, stable;
    logic [63:0] hold, r0, r1;

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 64'h0;
    out_ready = 1'b0;
    p_we = 1'b0;
    p_addr = 5'h0;
    p_wdata = 32'h0;
    sbox_zero = 1'b1;

    build_std_key();

    r0 = {$urandom, $urandom};
    r1 = {$urandom, $urandom};
    vecs[0] = '{1'b0, 64'h0123456789ABCDEF, 64'h89ABCDEF01234567};
    vecs[1] = '{1'b0, 64'hFFFFFFFF00000000, 64'h00000000FFFFFFFF};
    vecs[2] = '{1'b0, 64'hDEADBEEFCAFEF00D, 64'hCAFEF00DDEADBEEF};
    vecs[3] = '{1'b1, 64'h4EF997456198DD78, 64'h0000000000000000};
    vecs[4] = '{1'b1, enc(64'h0123456789ABCDEF), 64'h0123456789ABCDEF};
    vecs[5] = '{1'b1, enc(64'hFFFFFFFFFFFFFFFF), 64'hFFFFFFFFFFFFFFFF};
    vecs[6] = '{1'b1, enc(r0), r0};

    // Reset
    step();
    step();
    chk("reset in_ready", 64'(in_ready), 64'h1);
    chk("reset out_valid", 64'(out_valid), 64'h0);
    chk("reset busy", 64'(busy), 64'h0);
    chk("reset out_data", out_data, 64'h0);
    chk("reset sbox_rd", 64'(sbox_rd), 64'h0);
    rst = 1'b0;
    step();

    // First rounds with P=0, S=0: lookup strobe and index timing
    sbox_zero = 1'b1;
    load_p(1'b1);
    chk("idle sbox addr", {31'h0, sbox_rd, sbox_addr0, sbox_addr1, sbox_addr2, sbox_addr3}, 64'h0);
    accept(64'h0123456789ABCDEF);
    chk("lookup1 in_ready/busy", {62'h0, in_ready, busy}, 64'h1);
    chk("lookup1 sbox", {31'h0, sbox_rd, sbox_addr0, sbox_addr1, sbox_addr2, sbox_addr3},
        {31'h0, 1'b1, 32'h01234567});
    step();
    chk("calc1 sbox", {31'h0, sbox_rd, sbox_addr0, sbox_addr1, sbox_addr2, sbox_addr3}, 64'h0);
    step();
    chk("lookup2 sbox", {31'h0, sbox_rd, sbox_addr0, sbox_addr1, sbox_addr2, sbox_addr3},
        {31'h0, 1'b1, 32'h89ABCDEF});
    wait_out(lat);
    chk("zero key latency", 64'(lat + 2), LAT);
    chk("zero key data", out_data, 64'h89ABCDEF01234567);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Table of directed vectors
    cur_mode = 2;
    for (int i = 0; i < NV; i++) begin
      if (int'(vecs[i].std_key) != cur_mode) begin
        cur_mode = int'(vecs[i].std_key);
        sbox_zero = !vecs[i].std_key;
        load_p(!vecs[i].std_key);
      end
      run_block($sformatf("vec%0d", i), vecs[i].din, vecs[i].exp);
    end

    // Backpressure: output held, a waiting block is taken one clock after the handshake
    accept(enc(r1));
    wait_out(lat);
    chk("bp latency", 64'(lat), LAT);
    chk("bp data", out_data, r1);
    hold = out_data;
    in_valid = 1'b1;
    in_data = 64'h4EF997456198DD78;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_data !== hold || !out_valid || in_ready || !busy) stable = 1'b0;
    end
    chk("bp held stable", 64'(stable), 64'h1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp after handshake", {61'h0, in_ready, out_valid, busy}, 64'h4);
    step();
    in_valid = 1'b0;
    chk("bp accepted next clk", {62'h0, in_ready, busy}, 64'h1);
    wait_out(lat);
    chk("bp second latency", 64'(lat), LAT);
    chk("bp second data", out_data, 64'h0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // P writes while busy (including the accepting edge) are dropped; early out_ready is harmless
    in_valid = 1'b1;
    in_data = 64'h4EF997456198DD78;
    p_we = 1'b1;
    p_addr = 5'd5;
    p_wdata = 32'hDEADBEEF;
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    p_we = 1'b0;
    wait_out(lat);
    chk("busy write latency", 64'(lat + 5), LAT);
    chk("busy write data", out_data, 64'h0);
    step();
    chk("single-cycle valid", {62'h0, in_ready, out_valid}, 64'h2);
    out_ready = 1'b0;
    p_we = 1'b1;
    p_addr = 5'd18;
    p_wdata = 32'hDEADBEEF;
    step();
    p_addr = 5'd31;
    step();
    p_we = 1'b0;
    run_block("out-of-range write", 64'h4EF997456198DD78, 64'h0);

    // Reset mid-block: no output, P cleared, then normal operation after reload
    accept(64'h4EF997456198DD78);
    for (int i = 0; i < 13; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid rst state", {61'h0, in_ready, out_valid, busy}, 64'h4);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("mid rst no output", 64'(seen), 64'h0);
    sbox_zero = 1'b1;
    run_block("rst cleared P", 64'h0123456789ABCDEF, 64'h89ABCDEF01234567);
    sbox_zero = 1'b0;
    load_p(1'b0);
    run_block("after rst reload", 64'h4EF997456198DD78, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
